// File: rtl/pong_renderer_if.sv
// Game-state and video bundle between the Pong game logic and its VGA renderer.
// The game side drives positions, scores and the pixel strobe; the renderer
// returns sync, colour and the once-per-frame update strobe.
`timescale 1ns/1ps
interface pong_renderer_if;
    logic       pix_en;
    logic [9:0] ball_x;
    logic [9:0] ball_y;
    logic [9:0] paddle1_y;
    logic [9:0] paddle2_y;
    logic [3:0] score1;
    logic [3:0] score2;
    logic       hsync;
    logic       vsync;
    logic [3:0] vga_r;
    logic [3:0] vga_g;
    logic [3:0] vga_b;
    logic       frame_tick;

    modport master (
        output pix_en, ball_x, ball_y, paddle1_y, paddle2_y, score1, score2,
        input  hsync, vsync, vga_r, vga_g, vga_b, frame_tick
    );

    modport slave (
        input  pix_en, ball_x, ball_y, paddle1_y, paddle2_y, score1, score2,
        output hsync, vsync, vga_r, vga_g, vga_b, frame_tick
    );
endinterface

// File: rtl/pong_renderer.sv
// Pong VGA renderer: 640x480@60 scan timing, per-frame snapshot of the game
// state, two-stage pixel pipeline (region hits, then colour/sync) and a
// frame_tick strobe at the start of vertical blank.
`timescale 1ns/1ps
module pong_renderer #(
    parameter int H_ACTIVE      = 640,
    parameter int H_FP          = 16,
    parameter int H_SYNC        = 96,
    parameter int H_BP          = 48,
    parameter int V_ACTIVE      = 480,
    parameter int V_FP          = 10,
    parameter int V_SYNC        = 2,
    parameter int V_BP          = 33,
    parameter int PADDLE_WIDTH  = 10,
    parameter int PADDLE_HEIGHT = 50,
    parameter int BALL_WIDTH    = 10,
    parameter int BALL_HEIGHT   = 10
) (
    input  logic           clk,
    input  logic           reset,
    pong_renderer_if.slave vid
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0]  H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0]  V_TICK   = 10'(V_ACTIVE - 1);
    localparam logic [10:0] H_ACT    = 11'(H_ACTIVE);
    localparam logic [10:0] V_ACT    = 11'(V_ACTIVE);
    localparam logic [10:0] HS_START = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] VS_START = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] VS_END   = 11'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [10:0] PAD_W    = 11'(PADDLE_WIDTH);
    localparam logic [10:0] PAD_H    = 11'(PADDLE_HEIGHT);
    localparam logic [10:0] PAD2_X   = 11'(H_ACTIVE - PADDLE_WIDTH);
    localparam logic [10:0] BALL_W   = 11'(BALL_WIDTH);
    localparam logic [10:0] BALL_H   = 11'(BALL_HEIGHT);
    localparam logic [10:0] CL_X0    = 11'd318;
    localparam logic [10:0] CL_X1    = 11'd322;
    localparam logic [10:0] SC1_X    = 11'd256;
    localparam logic [10:0] SC2_X    = 11'd360;
    localparam logic [10:0] SC_Y     = 11'd16;
    localparam logic [10:0] SC_W     = 11'd24;
    localparam logic [10:0] SC_H     = 11'd40;

    logic [9:0]  h_cnt, v_cnt;
    logic        h_last, v_last;

    logic [9:0]  sh_ball_x, sh_ball_y, sh_paddle1_y, sh_paddle2_y;
    logic [3:0]  sh_score1, sh_score2;

    logic [10:0] hx, vy;
    logic        hit_active, hit_ball, hit_paddle, hit_score, hit_centre;
    logic        hs_raw, vs_raw;

    logic        s1_active, s1_ball, s1_paddle, s1_score, s1_centre, s1_hs, s1_vs;
    logic [11:0] rgb_q;
    logic        hs_q, vs_q;

    assign h_last = (h_cnt == H_LAST);
    assign v_last = (v_cnt == V_LAST);

    // Seven-segment lookup for one score digit; lx/ly are local to the 24x40 box.
    function automatic logic seg_pixel(input logic [3:0] val, input logic [10:0] lx,
                                       input logic [10:0] ly);
        logic [6:0] seg;
        case (val)
            4'd0:    seg = 7'b0111111;
            4'd1:    seg = 7'b0000110;
            4'd2:    seg = 7'b1011011;
            4'd3:    seg = 7'b1001111;
            4'd4:    seg = 7'b1100110;
            4'd5:    seg = 7'b1101101;
            4'd6:    seg = 7'b1111101;
            4'd7:    seg = 7'b0000111;
            4'd8:    seg = 7'b1111111;
            4'd9:    seg = 7'b1101111;
            default: seg = 7'b0000000;
        endcase
        return (seg[0] && ly < 11'd4)
            || (seg[1] && lx >= 11'd20 && ly < 11'd20)
            || (seg[2] && lx >= 11'd20 && ly >= 11'd20)
            || (seg[3] && ly >= 11'd36)
            || (seg[4] && lx < 11'd4 && ly >= 11'd20)
            || (seg[5] && lx < 11'd4 && ly < 11'd20)
            || (seg[6] && ly >= 11'd18 && ly < 11'd22);
    endfunction

    // Scan counters: h wraps every line, v advances on each h wrap.
    always_ff @(posedge clk) begin
        if (reset) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (vid.pix_en) begin
            if (h_last) begin
                h_cnt <= '0;
                v_cnt <= v_last ? 10'd0 : v_cnt + 10'd1;
            end else begin
                h_cnt <= h_cnt + 10'd1;
            end
        end
    end

    // Latch the game state on the very last pixel so a whole frame renders one state.
    always_ff @(posedge clk) begin
        if (reset) begin
            sh_ball_x    <= 10'd320;
            sh_ball_y    <= 10'd240;
            sh_paddle1_y <= 10'd215;
            sh_paddle2_y <= 10'd215;
            sh_score1    <= 4'd0;
            sh_score2    <= 4'd0;
        end else if (vid.pix_en && h_last && v_last) begin
            sh_ball_x    <= vid.ball_x;
            sh_ball_y    <= vid.ball_y;
            sh_paddle1_y <= vid.paddle1_y;
            sh_paddle2_y <= vid.paddle2_y;
            sh_score1    <= vid.score1;
            sh_score2    <= vid.score2;
        end
    end

    // Region and sync decode for the current scan position, in 11 bits so pos+size cannot wrap.
    always_comb begin
        hx = {1'b0, h_cnt};
        vy = {1'b0, v_cnt};
        hit_active = (hx < H_ACT) && (vy < V_ACT);
        hit_ball   = (hx >= {1'b0, sh_ball_x}) && (hx < {1'b0, sh_ball_x} + BALL_W)
                  && (vy >= {1'b0, sh_ball_y}) && (vy < {1'b0, sh_ball_y} + BALL_H);
        hit_paddle = ((hx < PAD_W)
                      && (vy >= {1'b0, sh_paddle1_y}) && (vy < {1'b0, sh_paddle1_y} + PAD_H))
                  || ((hx >= PAD2_X) && (hx < H_ACT)
                      && (vy >= {1'b0, sh_paddle2_y}) && (vy < {1'b0, sh_paddle2_y} + PAD_H));
        hit_score  = ((hx >= SC1_X) && (hx < SC1_X + SC_W) && (vy >= SC_Y) && (vy < SC_Y + SC_H)
                      && seg_pixel(sh_score1, hx - SC1_X, vy - SC_Y))
                  || ((hx >= SC2_X) && (hx < SC2_X + SC_W) && (vy >= SC_Y) && (vy < SC_Y + SC_H)
                      && seg_pixel(sh_score2, hx - SC2_X, vy - SC_Y));
        hit_centre = (hx >= CL_X0) && (hx < CL_X1) && !v_cnt[4];
        hs_raw     = !((hx >= HS_START) && (hx < HS_END));
        vs_raw     = !((vy >= VS_START) && (vy < VS_END));
    end

    // Pipeline stage 1: register region hits and raw sync levels.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_active <= 1'b0;
            s1_ball   <= 1'b0;
            s1_paddle <= 1'b0;
            s1_score  <= 1'b0;
            s1_centre <= 1'b0;
            s1_hs     <= 1'b1;
            s1_vs     <= 1'b1;
        end else if (vid.pix_en) begin
            s1_active <= hit_active;
            s1_ball   <= hit_ball;
            s1_paddle <= hit_paddle;
            s1_score  <= hit_score;
            s1_centre <= hit_centre;
            s1_hs     <= hs_raw;
            s1_vs     <= vs_raw;
        end
    end

    // Pipeline stage 2: resolve colour priority and blank outside the active area.
    always_ff @(posedge clk) begin
        if (reset) begin
            rgb_q <= 12'h000;
            hs_q  <= 1'b1;
            vs_q  <= 1'b1;
        end else if (vid.pix_en) begin
            if (!s1_active)
                rgb_q <= 12'h000;
            else if (s1_ball || s1_paddle || s1_score)
                rgb_q <= 12'hFFF;
            else if (s1_centre)
                rgb_q <= 12'h888;
            else
                rgb_q <= 12'h000;
            hs_q <= s1_hs;
            vs_q <= s1_vs;
        end
    end

    assign vid.hsync      = hs_q;
    assign vid.vsync      = vs_q;
    assign vid.vga_r      = rgb_q[11:8];
    assign vid.vga_g      = rgb_q[7:4];
    assign vid.vga_b      = rgb_q[3:0];
    assign vid.frame_tick = !reset && vid.pix_en && h_last && (v_cnt == V_TICK);
endmodule

// File: tb/tb_pong_renderer.sv
// Bench for pong_renderer, run on a reduced screen geometry (400x56 active,
// 416x60 total) so whole frames fit in a short run while keeping the score
// boxes, centre line and paddles at their fixed positions.
`timescale 1ns/1ps
module tb_pong_renderer;
    localparam int HA = 400, HFP = 4, HS = 8, HBP = 4;
    localparam int VA = 56,  VFP = 1, VS = 2, VBP = 1;
    localparam int HT = HA + HFP + HS + HBP;
    localparam int VT = VA + VFP + VS + VBP;
    localparam int FRAME = HT * VT;
    localparam logic [13:0] RST_OUT = 14'h3000;

    typedef struct {
        int bx; int by; int p1; int p2; int s1; int s2;
    } game_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    pong_renderer_if vid();

    pong_renderer #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
        .PADDLE_WIDTH(10), .PADDLE_HEIGHT(50), .BALL_WIDTH(10), .BALL_HEIGHT(10)
    ) dut (
        .clk(clk),
        .reset(reset),
        .vid(vid)
    );

    string seg_names [10] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg",
                              "acdfg", "acdefg", "abc", "abcdefg", "abcdfg"};

    game_t       shadow, inputs, defaults;
    int          k = 0;
    logic [13:0] exp_q [$];
    logic [13:0] exp_out = RST_OUT;
    int          compared = 0;
    int          mismatched = 0;
    int          ticks = 0;
    bit          capture_on = 1'b1;
    logic [11:0] img [2][VA][HA];

    function automatic bit in_box(int x, int y, int x0, int w, int y0, int h);
        return x >= x0 && x < x0 + w && y >= y0 && y < y0 + h;
    endfunction

    function automatic bit digit_lit(int v, int lx, int ly);
        string s;
        byte   c;
        if (v > 9 || lx < 0 || lx >= 24 || ly < 0 || ly >= 40) return 1'b0;
        s = seg_names[v];
        for (int i = 0; i < s.len(); i++) begin
            c = s[i];
            if (c == "a" && ly < 4) return 1'b1;
            if (c == "b" && lx >= 20 && ly < 20) return 1'b1;
            if (c == "c" && lx >= 20 && ly >= 20) return 1'b1;
            if (c == "d" && ly >= 36) return 1'b1;
            if (c == "e" && lx < 4 && ly >= 20) return 1'b1;
            if (c == "f" && lx < 4 && ly < 20) return 1'b1;
            if (c == "g" && ly >= 18 && ly < 22) return 1'b1;
        end
        return 1'b0;
    endfunction

    // What the screen should show at (x,y) for a given game state: {hsync, vsync, rgb}.
    function automatic logic [13:0] render(int x, int y, game_t g);
        logic        hs, vs;
        logic [11:0] rgb;
        hs  = !(x >= HA + HFP && x < HA + HFP + HS);
        vs  = !(y >= VA + VFP && y < VA + VFP + VS);
        rgb = 12'h000;
        if (x < HA && y < VA) begin
            if (in_box(x, y, g.bx, 10, g.by, 10) || in_box(x, y, 0, 10, g.p1, 50)
                || in_box(x, y, HA - 10, 10, g.p2, 50)
                || digit_lit(g.s1, x - 256, y - 16) || digit_lit(g.s2, x - 360, y - 16))
                rgb = 12'hFFF;
            else if (x >= 318 && x < 322 && ((y / 16) % 2 == 0))
                rgb = 12'h888;
        end
        return {hs, vs, rgb};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
        compared++;
        assert (got === want) else begin
            mismatched++;
            $error("[TB] FAIL %s k=%0d observed=%h expected=%h", tag, k, got, want);
        end
    endtask

    // One clock: drive at the falling edge, check frame_tick, then check outputs after the rise.
    task automatic applyStimulus(input bit en);
        logic        want_tick;
        logic [13:0] obs;
        int          p;
        @(negedge clk);
        vid.pix_en    = en;
        vid.ball_x    = 10'(inputs.bx);
        vid.ball_y    = 10'(inputs.by);
        vid.paddle1_y = 10'(inputs.p1);
        vid.paddle2_y = 10'(inputs.p2);
        vid.score1    = 4'(inputs.s1);
        vid.score2    = 4'(inputs.s2);
        #1;
        want_tick = !reset && en && (k % HT == HT - 1) && ((k / HT) % VT == VA - 1);
        checkOutput("frame_tick", 32'(vid.frame_tick), 32'(want_tick));
        if (vid.frame_tick === 1'b1) ticks++;
        @(posedge clk);
        #1;
        if (reset) begin
            k = 0;
            shadow = defaults;
            exp_q = {};
            exp_q.push_back(RST_OUT);
            exp_out = RST_OUT;
        end else if (en) begin
            exp_q.push_back(render(k % HT, (k / HT) % VT, shadow));
            if (k % FRAME == FRAME - 1) shadow = inputs;
            k++;
            exp_out = exp_q.pop_front();
        end
        obs = {vid.hsync, vid.vsync, vid.vga_r, vid.vga_g, vid.vga_b};
        checkOutput("scan_out", 32'(obs), 32'(exp_out));
        if (capture_on && !reset && en && k >= 2) begin
            p = k - 2;
            if (p / FRAME < 2 && p % HT < HA && (p / HT) % VT < VA)
                img[p / FRAME][(p / HT) % VT][p % HT] = obs[11:0];
        end
    endtask

    initial begin
        int nz;
        logic [13:0] obs;
        defaults = '{bx: 320, by: 240, p1: 215, p2: 215, s1: 0, s2: 0};
        inputs   = defaults;
        shadow   = defaults;

        $display("[TB] reset");
        reset = 1'b1;
        applyStimulus(1'b0);
        applyStimulus(1'b1);
        obs = {vid.hsync, vid.vsync, vid.vga_r, vid.vga_g, vid.vga_b};
        checkOutput("reset_state", 32'(obs), 32'(RST_OUT));
        reset = 1'b0;

        $display("[TB] frame 0, new game state arrives mid-frame");
        for (int n = 0; n < FRAME; n++) begin
            if (n == FRAME / 2)
                inputs = '{bx: 100, by: 20, p1: 5, p2: 30, s1: 7, s2: 12};
            if (n == FRAME / 2 + 7)
                inputs.s2 = $urandom_range(10, 15);
            if (n == FRAME / 2 + 9)
                inputs.s2 = 12;
            applyStimulus(1'b1);
        end

        $display("[TB] frame 1, ball_x moves mid-frame");
        for (int n = 0; n < 58 * HT + 300; n++) begin
            if (n == 10 * HT) inputs.bx = 200;
            if (n == 12 * HT) inputs.s1 = $urandom_range(0, 9);
            applyStimulus(1'b1);
        end
        capture_on = 1'b0;

        checkOutput("frame_ticks", 32'(ticks), 32'd2);

        checkOutput("f0_ball_not_yet", 32'(img[0][20][100]), 32'h000);
        checkOutput("f0_s2_zero_a",    32'(img[0][16][360]), 32'hFFF);
        checkOutput("f0_s1_zero_f",    32'(img[0][35][256]), 32'hFFF);
        checkOutput("f0_s1_zero_no_g", 32'(img[0][34][268]), 32'h000);
        checkOutput("ball_tl",         32'(img[1][20][100]), 32'hFFF);
        checkOutput("ball_br",         32'(img[1][29][109]), 32'hFFF);
        checkOutput("ball_right_out",  32'(img[1][20][110]), 32'h000);
        checkOutput("ball_below_out",  32'(img[1][30][100]), 32'h000);
        checkOutput("ball_no_tear",    32'(img[1][25][200]), 32'h000);
        checkOutput("pad1_top",        32'(img[1][5][9]),    32'hFFF);
        checkOutput("pad1_x_edge",     32'(img[1][5][10]),   32'h000);
        checkOutput("pad1_above",      32'(img[1][4][0]),    32'h000);
        checkOutput("pad1_last_row",   32'(img[1][54][0]),   32'hFFF);
        checkOutput("pad1_past_end",   32'(img[1][55][0]),   32'h000);
        checkOutput("pad2_left",       32'(img[1][30][390]), 32'hFFF);
        checkOutput("pad2_outside",    32'(img[1][30][389]), 32'h000);
        checkOutput("pad2_above",      32'(img[1][29][399]), 32'h000);
        checkOutput("s1_seven_a",      32'(img[1][16][256]), 32'hFFF);
        checkOutput("s1_seven_no_f",   32'(img[1][30][256]), 32'h000);
        checkOutput("s1_seven_b",      32'(img[1][30][276]), 32'hFFF);
        checkOutput("s1_seven_c",      32'(img[1][45][276]), 32'hFFF);
        checkOutput("s1_seven_no_d",   32'(img[1][53][265]), 32'h000);
        checkOutput("centre_dash",     32'(img[1][0][318]),  32'h888);
        checkOutput("centre_dash_r",   32'(img[1][0][321]),  32'h888);
        checkOutput("centre_x_edge",   32'(img[1][0][322]),  32'h000);
        checkOutput("centre_gap",      32'(img[1][16][318]), 32'h000);
        checkOutput("centre_dash2",    32'(img[1][32][319]), 32'h888);
        nz = 0;
        for (int y = 16; y < 56; y++)
            for (int x = 360; x < 384; x++)
                if (img[1][y][x] !== 12'h000) nz++;
        checkOutput("s2_twelve_blank", 32'(nz), 32'd0);

        $display("[TB] reset mid-frame at (300,58)");
        reset = 1'b1;
        applyStimulus(1'b1);
        obs = {vid.hsync, vid.vsync, vid.vga_r, vid.vga_g, vid.vga_b};
        checkOutput("mid_reset", 32'(obs), 32'(RST_OUT));
        reset = 1'b0;

        $display("[TB] pix_en every other clock");
        for (int n = 0; n < 2 * 20 * HT; n++)
            applyStimulus(n % 2 == 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
